// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider: emits a one-cycle tick and a divided level every
// cur_div cycles; ratio updates take effect only at period boundaries. Optional CLK_DIV_CTRL_CNT_EN adds period_cnt.
module clk_div_ctrl #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic [W-1:0] cur_div,
  output logic         busy,
  output logic         tick,
  output logic         div_out
`ifdef CLK_DIV_CTRL_CNT_EN
  ,
  output logic [15:0]  period_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] TWO      = W'(2);
  localparam logic [W-1:0] DIV_INIT = W'(DEFAULT_DIV);

  state_t       state_reg, state_next;
  logic [W-1:0] cnt_reg, cnt_next;
  logic [W-1:0] cur_div_reg, cur_div_next;
  logic [W-1:0] pend_div_reg, pend_div_next;
  logic         pend_valid_reg, pend_valid_next;
  logic         tick_reg, tick_next;
  logic         div_out_reg, div_out_next;
  logic         busy_reg, busy_next;
  logic         cfg_ready_reg, cfg_ready_next;
  logic         cfg_err_reg, cfg_err_next;

  logic         active;
  logic         boundary;
  logic         cfg_fire;
  logic         cfg_legal;
  logic         running_next;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    cur_div_next    = cur_div_reg;
    pend_div_next   = pend_div_reg;
    pend_valid_next = pend_valid_reg;

    active    = (state_reg != ST_IDLE);
    boundary  = active && (cnt_reg == cur_div_reg - ONE);
    cfg_fire  = cfg_valid && cfg_ready_reg;
    cfg_legal = (cfg_div >= TWO);

    unique case (state_reg)
      ST_IDLE: begin
        if (start && !stop) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (stop) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A resume request wins over the drain boundary so ticks never stall.
        if (start) state_next = ST_RUN;
        else if (boundary) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (!active || state_next == ST_IDLE || boundary) cnt_next = '0;
    else cnt_next = cnt_reg + ONE;

    // A pending ratio was captured before this boundary, so it owns the next period.
    if (pend_valid_reg && boundary) begin
      cur_div_next    = pend_div_reg;
      pend_valid_next = 1'b0;
    end

    if (cfg_fire && cfg_legal) begin
      if (!active) begin
        cur_div_next = cfg_div;
      end else begin
        pend_div_next   = cfg_div;
        pend_valid_next = 1'b1;
      end
    end

    // Outputs are registered, so they are predicted from the next-cycle state.
    running_next   = (state_next != ST_IDLE);
    tick_next      = running_next && (cnt_next == cur_div_next - ONE);
    div_out_next   = running_next && (cnt_next < (cur_div_next >> 1));
    busy_next      = running_next;
    cfg_ready_next = !pend_valid_next;
    cfg_err_next   = cfg_fire && !cfg_legal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      cur_div_reg    <= DIV_INIT;
      pend_div_reg   <= '0;
      pend_valid_reg <= 1'b0;
      tick_reg       <= 1'b0;
      div_out_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      cfg_ready_reg  <= 1'b1;
      cfg_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      cur_div_reg    <= cur_div_next;
      pend_div_reg   <= pend_div_next;
      pend_valid_reg <= pend_valid_next;
      tick_reg       <= tick_next;
      div_out_reg    <= div_out_next;
      busy_reg       <= busy_next;
      cfg_ready_reg  <= cfg_ready_next;
      cfg_err_reg    <= cfg_err_next;
    end
  end

`ifdef CLK_DIV_CTRL_CNT_EN
  logic [15:0] period_cnt_reg;

  // Counts alongside the registered tick so the value already includes the visible tick.
  always_ff @(posedge clk) begin
    if (reset) period_cnt_reg <= '0;
    else if (tick_next) period_cnt_reg <= period_cnt_reg + 16'd1;
  end

  assign period_cnt = period_cnt_reg;
`endif

  assign cfg_ready = cfg_ready_reg;
  assign cfg_err   = cfg_err_reg;
  assign cur_div   = cur_div_reg;
  assign busy      = busy_reg;
  assign tick      = tick_reg;
  assign div_out   = div_out_reg;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed vector table, hand sequences for
// long ratios and reset-with-pending, and randomized traffic against a behavioural model.
module tb_clk_div_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready, cfg_err, busy, tick, div_out;
  logic [7:0] cur_div;
`ifdef CLK_DIV_CTRL_CNT_EN
  logic [15:0] period_cnt;
`endif

  int checks = 0;
  int errors = 0;

  clk_div_ctrl #(.W(8), .DEFAULT_DIV(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cur_div   (cur_div),
    .busy      (busy),
    .tick      (tick),
    .div_out   (div_out)
`ifdef CLK_DIV_CTRL_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s, p, v;
    logic [7:0] d;
    logic       t, dv, b, r, e;
    logic [7:0] c;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: mode 0 idle, 1 running, 2 finishing the current period.
  int m_mode, m_pos, m_ratio, m_pend, m_ticks;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic s, p, v, input logic [7:0] d,
                      input logic t, dv, b, r, e, input logic [7:0] c);
    vec_t x;
    x.s = s; x.p = p; x.v = v; x.d = d;
    x.t = t; x.dv = dv; x.b = b; x.r = r; x.e = e; x.c = c;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic s, p, v, input logic [7:0] d);
    start = s; stop = p; cfg_valid = v; cfg_div = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_ratio = 3; m_pend = -1; m_ticks = 0; m_err = 0;
  endtask

  function automatic bit m_tick();
    return (m_mode != 0) && (m_pos == m_ratio - 1);
  endfunction

  function automatic bit m_div();
    return (m_mode != 0) && (m_pos < m_ratio / 2);
  endfunction

  task automatic model_advance(input bit s, p, v, input int d);
    bit at_end, fire;
    int nmode;
    at_end = m_tick();
    fire   = v && (m_pend < 0);
    m_err  = fire && (d < 2);
    nmode  = m_mode;
    if (m_mode == 0) begin
      if (s && !p) nmode = 1;
    end else if (m_mode == 1) begin
      if (p) nmode = 2;
    end else begin
      if (s) nmode = 1;
      else if (at_end) nmode = 0;
    end
    if (m_mode == 0 || nmode == 0) m_pos = 0;
    else m_pos = (m_pos + 1) % m_ratio;
    if (at_end && m_pend >= 0) begin
      m_ratio = m_pend;
      m_pend  = -1;
    end
    if (fire && d >= 2) begin
      if (m_mode == 0) m_ratio = d;
      else m_pend = d;
    end
    m_mode = nmode;
    if (m_tick()) m_ticks++;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tick"},      32'(tick),      32'd0);
    chk({tag, "_div_out"},   32'(div_out),   32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_cfg_err"},   32'(cfg_err),   32'd0);
    chk({tag, "_cur_div"},   32'(cur_div),   32'd3);
  endtask

  initial begin
    int n, hi;
    bit s, p, v;
    int d;

    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_vals("reset");

    //    s  p  v  d       t  dv b  r  e  cur
    addv(1, 0, 0, 8'd0,   0, 1, 1, 1, 0, 8'd3);
    addv(0, 0, 0, 8'd0,   0, 0, 1, 1, 0, 8'd3);
    addv(0, 0, 0, 8'd0,   1, 0, 1, 1, 0, 8'd3);
    addv(0, 0, 0, 8'd0,   0, 1, 1, 1, 0, 8'd3);
    addv(0, 0, 1, 8'd5,   0, 0, 1, 0, 0, 8'd3);
    addv(0, 0, 0, 8'd0,   1, 0, 1, 0, 0, 8'd3);
    addv(0, 0, 0, 8'd0,   0, 1, 1, 1, 0, 8'd5);
    addv(0, 0, 0, 8'd0,   0, 1, 1, 1, 0, 8'd5);
    addv(0, 0, 0, 8'd0,   0, 0, 1, 1, 0, 8'd5);
    addv(0, 0, 0, 8'd0,   0, 0, 1, 1, 0, 8'd5);
    addv(0, 0, 0, 8'd0,   1, 0, 1, 1, 0, 8'd5);
    addv(0, 0, 1, 8'd1,   0, 1, 1, 1, 1, 8'd5);
    addv(0, 0, 1, 8'd0,   0, 1, 1, 1, 1, 8'd5);
    addv(0, 0, 0, 8'd0,   0, 0, 1, 1, 0, 8'd5);
    addv(0, 1, 0, 8'd0,   0, 0, 1, 1, 0, 8'd5);
    addv(0, 0, 0, 8'd0,   1, 0, 1, 1, 0, 8'd5);
    addv(0, 0, 0, 8'd0,   0, 0, 0, 1, 0, 8'd5);
    addv(0, 0, 1, 8'd4,   0, 0, 0, 1, 0, 8'd4);
    addv(1, 0, 0, 8'd0,   0, 1, 1, 1, 0, 8'd4);
    addv(0, 0, 0, 8'd0,   0, 1, 1, 1, 0, 8'd4);
    addv(0, 1, 0, 8'd0,   0, 0, 1, 1, 0, 8'd4);
    addv(0, 0, 0, 8'd0,   1, 0, 1, 1, 0, 8'd4);
    addv(0, 0, 0, 8'd0,   0, 0, 0, 1, 0, 8'd4);
    addv(1, 0, 0, 8'd0,   0, 1, 1, 1, 0, 8'd4);
    addv(0, 0, 0, 8'd0,   0, 1, 1, 1, 0, 8'd4);
    addv(0, 1, 0, 8'd0,   0, 0, 1, 1, 0, 8'd4);
    addv(1, 0, 0, 8'd0,   1, 0, 1, 1, 0, 8'd4);
    addv(0, 0, 0, 8'd0,   0, 1, 1, 1, 0, 8'd4);
    addv(0, 0, 0, 8'd0,   0, 1, 1, 1, 0, 8'd4);
    addv(0, 0, 0, 8'd0,   0, 0, 1, 1, 0, 8'd4);
    addv(0, 0, 0, 8'd0,   1, 0, 1, 1, 0, 8'd4);
    addv(0, 0, 1, 8'd2,   0, 1, 1, 0, 0, 8'd4);
    addv(0, 0, 0, 8'd0,   0, 1, 1, 0, 0, 8'd4);
    addv(0, 0, 0, 8'd0,   0, 0, 1, 0, 0, 8'd4);
    addv(0, 0, 0, 8'd0,   1, 0, 1, 0, 0, 8'd4);
    addv(0, 0, 0, 8'd0,   0, 1, 1, 1, 0, 8'd2);
    addv(0, 0, 0, 8'd0,   1, 0, 1, 1, 0, 8'd2);
    addv(0, 0, 0, 8'd0,   0, 1, 1, 1, 0, 8'd2);
    addv(0, 1, 0, 8'd0,   1, 0, 1, 1, 0, 8'd2);
    addv(0, 0, 0, 8'd0,   0, 0, 0, 1, 0, 8'd2);
    addv(1, 1, 0, 8'd0,   0, 0, 0, 1, 0, 8'd2);
    addv(0, 0, 0, 8'd0,   0, 0, 0, 1, 0, 8'd2);

    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].p, vecs[i].v, vecs[i].d);
      $display("vec %0d: s=%0b p=%0b v=%0b d=%0d -> tick=%0b div=%0b busy=%0b rdy=%0b err=%0b cur=%0d",
               i, vecs[i].s, vecs[i].p, vecs[i].v, vecs[i].d,
               tick, div_out, busy, cfg_ready, cfg_err, cur_div);
      chk($sformatf("vec%0d_tick", i),      32'(tick),      32'(vecs[i].t));
      chk($sformatf("vec%0d_div_out", i),   32'(div_out),   32'(vecs[i].dv));
      chk($sformatf("vec%0d_busy", i),      32'(busy),      32'(vecs[i].b));
      chk($sformatf("vec%0d_cfg_ready", i), 32'(cfg_ready), 32'(vecs[i].r));
      chk($sformatf("vec%0d_cfg_err", i),   32'(cfg_err),   32'(vecs[i].e));
      chk($sformatf("vec%0d_cur_div", i),   32'(cur_div),   32'(vecs[i].c));
    end

    // Largest ratio: one period of 255 cycles, 127 of them with div_out high.
    do_reset();
    drive(0, 0, 1, 8'd255);
    chk("max_cur_div", 32'(cur_div), 32'd255);
    drive(1, 0, 0, 8'd0);
    n = 1;
    hi = int'(div_out);
    while (!tick && n < 300) begin
      drive(0, 0, 0, 8'd0);
      n++;
      hi += int'(div_out);
    end
    $display("max ratio: first tick after %0d cycles, div_out high %0d cycles", n, hi);
    chk("max_period", 32'(n), 32'd255);
    chk("max_div_high", 32'(hi), 32'd127);

    // Reset while a ratio is pending: everything returns to reset values, ratio dropped.
    do_reset();
    drive(1, 0, 0, 8'd0);
    drive(0, 0, 0, 8'd0);
    drive(0, 0, 1, 8'd7);
    chk("pend_cfg_ready", 32'(cfg_ready), 32'd0);
    reset = 1'b1;
    drive(0, 0, 0, 8'd0);
    reset = 1'b0;
    $display("reset with pending ratio: busy=%0b rdy=%0b cur=%0d", busy, cfg_ready, cur_div);
    chk_reset_vals("midreset");
    drive(1, 0, 0, 8'd0);
    drive(0, 0, 0, 8'd0);
    chk("midreset_no_early_tick", 32'(tick), 32'd0);
    drive(0, 0, 0, 8'd0);
    chk("midreset_tick_at_3", 32'(tick), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      s = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 14) == 0);
      v = ($urandom_range(0, 5) == 0);
      d = $urandom_range(0, 9);
      if (v && cfg_ready) $display("rand cyc %0d: cfg transfer div=%0d", cyc, d);
      model_advance(s, p, v, d);
      drive(s, p, v, 8'(d));
      chk("rand_tick",      32'(tick),      32'(m_tick()));
      chk("rand_div_out",   32'(div_out),   32'(m_div()));
      chk("rand_busy",      32'(busy),      32'(m_mode != 0));
      chk("rand_cfg_ready", 32'(cfg_ready), 32'(m_pend < 0));
      chk("rand_cfg_err",   32'(cfg_err),   32'(m_err));
      chk("rand_cur_div",   32'(cur_div),   32'(m_ratio));
`ifdef CLK_DIV_CTRL_CNT_EN
      chk("rand_period_cnt", 32'(period_cnt), 32'(m_ticks % 65536));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
